// File: rtl/uart_rx_fifo_pkg.sv
// Shared types for the UART receiver: FSM state encoding, data-bit
// selector encoding and the receive FIFO entry layout.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } uart_state_e;

  typedef enum logic [1:0] {
    BITS5 = 2'd0,
    BITS6 = 2'd1,
    BITS7 = 2'd2,
    BITS8 = 2'd3
  } uart_bits_e;

  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// Small circular receive buffer with pointers and occupancy count.
// A pop on a full buffer frees the slot that a same-cycle push then uses.
module uart_rx_fifo_buf import uart_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = rx_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with runtime frame format and a receive FIFO.
// Optional break detection (brk_o) is built when UART_RX_BREAK_DET_EN is defined.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_en_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [1:0]       cfg_bits_i,
  input  logic             cfg_parity_en_i,
  input  logic             cfg_parity_odd_i,
  input  logic             cfg_stop2_i,
  input  logic             rx_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_perr_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             err_frame_o,
  output logic             err_overrun_o,
  input  logic             err_clr_i,
  output logic             busy_o
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic             brk_o
`endif
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] S_V2  = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, armed_q;
  uart_state_e            state_q;
  logic [DIV_W-1:0]       div_q, div_cnt_q;
  logic [SW-1:0]          samp_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             data_q;
  logic                   s0_q, s1_q, bit_q, perr_q;
  uart_bits_e             bits_q;
  logic                   par_en_q, odd_q, stop2_q;
  logic                   err_frame_q, err_overrun_q;
  logic                   tick, vote, at_vote, at_end, start_go, stop_vote;
  logic                   push, frame_set, ovr_set;
  rx_entry_t              push_entry, head;
  logic                   full, empty;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign tick      = cfg_en_i && (state_q != IDLE) && (div_cnt_q == '0);
  assign at_vote   = tick && (samp_q == S_V2);
  assign at_end    = tick && (samp_q == S_END);
  assign vote      = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  // armed_q means rx was high in IDLE last cycle, so this is a true falling edge
  assign start_go  = (state_q == IDLE) && cfg_en_i && armed_q && !rx_s;
  assign stop_vote = at_vote && ((state_q == STOP) || (state_q == STOP2));
  assign push      = stop_vote && vote && !((state_q == STOP) && stop2_q);
  assign busy_o    = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '1;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
      armed_q <= (state_q == IDLE) && rx_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      div_q     <= '0;
      div_cnt_q <= '0;
      samp_q    <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      bit_q     <= 1'b1;
      perr_q    <= 1'b0;
      bits_q    <= BITS8;
      par_en_q  <= 1'b0;
      odd_q     <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (!cfg_en_i) begin
      state_q <= IDLE;
    end else if (start_go) begin
      // Frame format is captured here and held for the whole frame
      state_q   <= START;
      div_q     <= cfg_div_i;
      div_cnt_q <= cfg_div_i;
      samp_q    <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      bits_q    <= uart_bits_e'(cfg_bits_i);
      par_en_q  <= cfg_parity_en_i;
      odd_q     <= cfg_parity_odd_i;
      stop2_q   <= cfg_stop2_i;
    end else if (tick) begin
      div_cnt_q <= div_q;
      samp_q    <= samp_q + 1'b1;
      if (samp_q == S_V0) s0_q  <= rx_s;
      if (samp_q == S_V1) s1_q  <= rx_s;
      if (samp_q == S_V2) bit_q <= vote;
      case (state_q)
        START: if (at_end) state_q <= bit_q ? IDLE : DATA;
        DATA: begin
          if (at_vote) data_q[bit_cnt_q] <= vote;
          if (at_end) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == ({1'b0, bits_q} + 3'd4))
              state_q <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (at_vote) perr_q <= ^data_q ^ vote ^ odd_q;
          if (at_end) state_q <= STOP;
        end
        STOP, STOP2: begin
          // Leave at the stop-bit vote so the next start edge has half a bit of margin
          if (at_vote && (!vote || !((state_q == STOP) && stop2_q)))
            state_q <= IDLE;
          else if (at_end && (state_q == STOP))
            state_q <= STOP2;
        end
        default: state_q <= IDLE;
      endcase
    end else if (state_q != IDLE) begin
      div_cnt_q <= div_cnt_q - 1'b1;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic zero_q, brk_q, brk_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zero_q <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      if (start_go) zero_q <= 1'b1;
      else if (at_vote && vote && ((state_q == DATA) || (state_q == PARITY))) zero_q <= 1'b0;
      if (brk_set) brk_q <= 1'b1;
      else if (err_clr_i) brk_q <= 1'b0;
    end
  end

  assign brk_set   = stop_vote && !vote && zero_q;
  assign frame_set = stop_vote && !vote && !zero_q;
  assign brk_o     = brk_q;
`else
  assign frame_set = stop_vote && !vote;
`endif

  // Read port: rx_valid_o/rx_ready_i handshake; an entry leaves the FIFO on
  // a clock edge where both are high, and data/perr are stable while valid waits.
  assign push_entry = {perr_q, data_q};
  assign ovr_set    = push && full && !(rx_ready_i && !empty);

  uart_rx_fifo_buf #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (rx_entry_t)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (rx_ready_i),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rx_valid_o = !empty;
  assign rx_data_o  = empty ? 8'h00 : head.data;
  assign rx_perr_o  = !empty && head.perr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      if (frame_set) err_frame_q <= 1'b1;
      else if (err_clr_i) err_frame_q <= 1'b0;
      if (ovr_set) err_overrun_q <= 1'b1;
      else if (err_clr_i) err_overrun_q <= 1'b0;
    end
  end

  assign err_frame_o   = err_frame_q;
  assign err_overrun_o = err_overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, hand-written corner
// sequences and randomized frames checked against a queue-based model.
module tb_uart_rx_fifo;
  localparam int OS    = 16;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_en_i = 1'b0;
  logic [15:0] cfg_div_i = 16'd3;
  logic [1:0]  cfg_bits_i = 2'd3;
  logic        cfg_parity_en_i = 1'b0;
  logic        cfg_parity_odd_i = 1'b0;
  logic        cfg_stop2_i = 1'b0;
  logic        rx_i = 1'b1;
  logic [7:0]  rx_data_o;
  logic        rx_perr_o, rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic        err_frame_o, err_overrun_o;
  logic        err_clr_i = 1'b0;
  logic        busy_o;
`ifdef UART_RX_BREAK_DET_EN
  logic        brk_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  uart_rx_fifo #(.OVERSAMPLE(OS), .DIV_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_en_i(cfg_en_i), .cfg_div_i(cfg_div_i),
    .cfg_bits_i(cfg_bits_i), .cfg_parity_en_i(cfg_parity_en_i),
    .cfg_parity_odd_i(cfg_parity_odd_i), .cfg_stop2_i(cfg_stop2_i), .rx_i(rx_i),
    .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .err_frame_o(err_frame_o), .err_overrun_o(err_overrun_o),
    .err_clr_i(err_clr_i), .busy_o(busy_o)
`ifdef UART_RX_BREAK_DET_EN
    , .brk_o(brk_o)
`endif
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] data;
    int         nb;
    bit         pe, po, s2, fl, sl;
    int         dv;
    bit         exp_push;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_frame;
  } vec_t;

  vec_t vecs[7];

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input int nb, input bit pe, input bit po, input bit s2, input int dv);
    cfg_bits_i       = 2'(nb - 5);
    cfg_parity_en_i  = pe;
    cfg_parity_odd_i = po;
    cfg_stop2_i      = s2;
    cfg_div_i        = 16'(dv);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pe, input bit po,
                            input bit s2, input bit fl, input bit sl, input int bclk);
    logic [7:0] m;
    bit par;
    m   = 8'((9'h1 << nb) - 9'h1);
    par = ((($countones(d & m) % 2) == 1) ^ po) ^ fl;
    rx_i = 1'b0; wait_clk(bclk);
    for (int i = 0; i < nb; i++) begin
      rx_i = d[i]; wait_clk(bclk);
    end
    if (pe) begin
      rx_i = par; wait_clk(bclk);
    end
    rx_i = ~sl; wait_clk(s2 ? 2 * bclk : bclk);
    rx_i = 1'b1; wait_clk(2 * bclk);
  endtask

  task automatic pop_check(input string name, input logic [8:0] exp);
    int t;
    t = 0;
    @(negedge clk_i);
    while (!rx_valid_o && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    check_bit({name, " valid"}, rx_valid_o, 1'b1);
    check_byte({name, " data"}, rx_data_o, exp[7:0]);
    check_bit({name, " perr"}, rx_perr_o, exp[8]);
    rx_ready_i = 1'b1;
    wait_clk(1);
    rx_ready_i = 1'b0;
  endtask

  task automatic clr_err();
    err_clr_i = 1'b1;
    wait_clk(1);
    err_clr_i = 1'b0;
  endtask

  initial begin
    logic [7:0] d, m;
    int nb, dv, ones;
    bit pe, po, s2, fl, sl, par, exp_ovr;

    vecs[0] = '{8'hA5, 8, 0, 0, 0, 0, 0, 26, 1, 8'hA5, 0, 0};
    vecs[1] = '{8'h35, 7, 1, 0, 1, 0, 0, 3,  1, 8'h35, 0, 0};
    vecs[2] = '{8'h35, 7, 1, 0, 1, 1, 0, 3,  1, 8'h35, 1, 0};
    vecs[3] = '{8'h3C, 8, 0, 0, 0, 0, 1, 3,  0, 8'h00, 0, 1};
    vecs[4] = '{8'hFF, 5, 1, 1, 0, 0, 0, 3,  1, 8'h1F, 0, 0};
    vecs[5] = '{8'h6B, 6, 0, 0, 1, 0, 0, 3,  1, 8'h2B, 0, 0};
    vecs[6] = '{8'hC3, 8, 1, 1, 0, 1, 0, 3,  1, 8'hC3, 1, 0};

    // reset state
    wait_clk(5);
    check_bit("rst valid", rx_valid_o, 1'b0);
    check_byte("rst data", rx_data_o, 8'h00);
    check_bit("rst perr", rx_perr_o, 1'b0);
    check_bit("rst frame", err_frame_o, 1'b0);
    check_bit("rst overrun", err_overrun_o, 1'b0);
    check_bit("rst busy", busy_o, 1'b0);
    rst_ni = 1'b1;
    cfg_en_i = 1'b1;
    wait_clk(5);

    // vector table
    foreach (vecs[i]) begin
      set_cfg(vecs[i].nb, vecs[i].pe, vecs[i].po, vecs[i].s2, vecs[i].dv);
      send_frame(vecs[i].data, vecs[i].nb, vecs[i].pe, vecs[i].po, vecs[i].s2,
                 vecs[i].fl, vecs[i].sl, (vecs[i].dv + 1) * OS);
      if (vecs[i].exp_push) begin
        pop_check($sformatf("vec%0d", i), {vecs[i].exp_perr, vecs[i].exp_data});
      end else begin
        @(negedge clk_i);
        check_bit($sformatf("vec%0d no push", i), rx_valid_o, 1'b0);
      end
      @(negedge clk_i);
      check_bit($sformatf("vec%0d frame", i), err_frame_o, vecs[i].exp_frame);
      check_bit($sformatf("vec%0d overrun", i), err_overrun_o, 1'b0);
      clr_err();
      @(negedge clk_i);
      check_bit($sformatf("vec%0d frame clr", i), err_frame_o, 1'b0);
    end

    // overrun: no reads while five frames arrive
    set_cfg(8, 0, 0, 0, 3);
    exp_ovr = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 8, 0, 0, 0, 0, 0, 4 * OS);
      if (exp_q.size() < DEPTH) exp_q.push_back({1'b0, 8'(v)});
      else exp_ovr = 1'b1;
      @(negedge clk_i);
      check_bit($sformatf("ovr flag after %0d", v), err_overrun_o, exp_ovr);
    end
    while (exp_q.size() > 0) pop_check("ovr drain", exp_q.pop_front());
    @(negedge clk_i);
    check_bit("ovr empty", rx_valid_o, 1'b0);
    clr_err();
    @(negedge clk_i);
    check_bit("ovr clr", err_overrun_o, 1'b0);

    // glitch: 3-tick low pulse
    rx_i = 1'b0; wait_clk(3 * 4);
    rx_i = 1'b1; wait_clk(2);
    @(negedge clk_i);
    check_bit("glitch busy", busy_o, 1'b1);
    wait_clk(2 * 4 * OS);
    @(negedge clk_i);
    check_bit("glitch idle", busy_o, 1'b0);
    check_bit("glitch no push", rx_valid_o, 1'b0);
    check_bit("glitch frame", err_frame_o, 1'b0);

    // abort: drop enable mid-frame with one entry buffered
    send_frame(8'h77, 8, 0, 0, 0, 0, 0, 4 * OS);
    rx_i = 1'b0; wait_clk(64);
    rx_i = 1'b1; wait_clk(64);
    rx_i = 1'b0; wait_clk(32);
    @(negedge clk_i);
    check_bit("abort busy before", busy_o, 1'b1);
    wait_clk(1);
    cfg_en_i = 1'b0;
    wait_clk(1);
    @(negedge clk_i);
    check_bit("abort busy after", busy_o, 1'b0);
    check_bit("abort valid kept", rx_valid_o, 1'b1);
    check_byte("abort data kept", rx_data_o, 8'h77);
    rx_i = 1'b1; wait_clk(64);
    cfg_en_i = 1'b1; wait_clk(128);
    check_bit("abort frame", err_frame_o, 1'b0);
    pop_check("abort entry", {1'b0, 8'h77});
    @(negedge clk_i);
    check_bit("abort empty", rx_valid_o, 1'b0);

    // reset during DATA with a buffered entry
    send_frame(8'h11, 8, 0, 0, 0, 0, 0, 4 * OS);
    rx_i = 1'b0; wait_clk(64);
    rx_i = 1'b0; wait_clk(64);
    rx_i = 1'b1; wait_clk(64);
    check_bit("midrst busy before", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_bit("midrst valid", rx_valid_o, 1'b0);
    check_byte("midrst data", rx_data_o, 8'h00);
    check_bit("midrst perr", rx_perr_o, 1'b0);
    check_bit("midrst busy", busy_o, 1'b0);
    check_bit("midrst frame", err_frame_o, 1'b0);
    check_bit("midrst overrun", err_overrun_o, 1'b0);
    wait_clk(5);
    rst_ni = 1'b1;
    wait_clk(10);
    send_frame(8'h5A, 8, 0, 0, 0, 0, 0, 4 * OS);
    pop_check("midrst 5A", {1'b0, 8'h5A});
    check_bit("midrst 5A frame", err_frame_o, 1'b0);

    // randomized frames against the model
    for (int k = 0; k < 14; k++) begin
      d  = 8'($urandom_range(255, 0));
      nb = $urandom_range(8, 5);
      pe = 1'($urandom_range(1, 0));
      po = 1'($urandom_range(1, 0));
      s2 = 1'($urandom_range(1, 0));
      fl = pe && ($urandom_range(3, 0) == 0);
      sl = ($urandom_range(6, 0) == 0);
      dv = $urandom_range(4, 2);
      if (sl) d[0] = 1'b1;
      set_cfg(nb, pe, po, s2, dv);
      send_frame(d, nb, pe, po, s2, fl, sl, (dv + 1) * OS);
      if (!sl) begin
        m    = 8'((9'h1 << nb) - 9'h1);
        par  = ((($countones(d & m) % 2) == 1) ^ po) ^ fl;
        ones = $countones(d & m) + (pe ? int'(par) : 0);
        exp_q.push_back({pe && ((ones % 2) != int'(po)), d & m});
      end
      @(negedge clk_i);
      check_bit($sformatf("rand%0d frame", k), err_frame_o, sl);
      clr_err();
      if (exp_q.size() >= 2 || k == 13) begin
        while (exp_q.size() > 0) pop_check($sformatf("rand%0d", k), exp_q.pop_front());
      end
    end
    @(negedge clk_i);
    check_bit("rand empty", rx_valid_o, 1'b0);
    check_bit("rand overrun", err_overrun_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
